// File: rtl/enemy_sprite_plotter_if.sv
// Request/VGA bundle between the enemy datapath (master) and the sprite plotter (slave).
interface enemy_sprite_plotter_if;
    logic       start_plot;
    logic       write_en;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    modport master (
        output start_plot, write_en, x_in, y_in, colour_in,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  start_plot, write_en, x_in, y_in, colour_in,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done
    );
endinterface

// File: rtl/enemy_sprite_plotter.sv
// Rasterises a W x H solid box, one pixel per clock, with screen-edge clipping.
// Define ENEMY_PLOT_ERASE_EN to erase the previously drawn box in BG_COLOUR first.
module enemy_sprite_plotter #(
    parameter int unsigned W         = 8,
    parameter int unsigned H         = 8,
    parameter int unsigned MAX_X     = 160,
    parameter int unsigned MAX_Y     = 120,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic                         clock,
    input  logic                         reset_n,
    enemy_sprite_plotter_if.slave        bus
);

    localparam logic [3:0] CxLast = 4'(W - 1);
    localparam logic [3:0] CyLast = 4'(H - 1);
    localparam logic [8:0] MaxX   = 9'(MAX_X);
    localparam logic [7:0] MaxY   = 8'(MAX_Y);

`ifdef ENEMY_PLOT_ERASE_EN
    typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;
`endif

    state_e     r_state;
    logic [3:0] r_cx;
    logic [3:0] r_cy;
    logic [7:0] r_ox;
    logic [6:0] r_oy;
    logic [2:0] r_colour;
    logic [7:0] r_vga_x;
    logic [6:0] r_vga_y;
    logic [2:0] r_vga_colour;
    logic       r_vga_plot;
    logic       r_busy;
    logic       r_done;

    logic [7:0] w_prev_ox;
    logic [6:0] w_prev_oy;
    logic       w_prev_valid;

`ifdef ENEMY_PLOT_ERASE_EN
    logic [7:0] r_prev_ox;
    logic [6:0] r_prev_oy;
    logic       r_prev_valid;

    assign w_prev_ox    = r_prev_ox;
    assign w_prev_oy    = r_prev_oy;
    assign w_prev_valid = r_prev_valid;
`else
    assign w_prev_ox    = r_ox;
    assign w_prev_oy    = r_oy;
    assign w_prev_valid = 1'b0;
`endif

    logic       w_req;
    logic       w_last;
    logic [3:0] w_cx_nxt;
    logic [3:0] w_cy_nxt;

    assign w_req  = bus.start_plot & bus.write_en;
    assign w_last = (r_cx == CxLast) && (r_cy == CyLast);

    always_comb begin
        if (r_cx == CxLast) begin
            w_cx_nxt = 4'd0;
            w_cy_nxt = r_cy + 4'd1;
        end else begin
            w_cx_nxt = r_cx + 4'd1;
            w_cy_nxt = r_cy;
        end
    end

    // Origin, counter and colour of the pixel that the next edge registers onto the outputs.
    logic [7:0] w_sel_ox;
    logic [6:0] w_sel_oy;
    logic [3:0] w_sel_cx;
    logic [3:0] w_sel_cy;
    logic [2:0] w_sel_colour;

    always_comb begin
        w_sel_ox     = r_ox;
        w_sel_oy     = r_oy;
        w_sel_cx     = w_cx_nxt;
        w_sel_cy     = w_cy_nxt;
        w_sel_colour = r_colour;
        case (r_state)
            StIdle: begin
                w_sel_cx = 4'd0;
                w_sel_cy = 4'd0;
                if (w_prev_valid) begin
                    w_sel_ox     = w_prev_ox;
                    w_sel_oy     = w_prev_oy;
                    w_sel_colour = BG_COLOUR;
                end else begin
                    w_sel_ox     = bus.x_in;
                    w_sel_oy     = bus.y_in;
                    w_sel_colour = bus.colour_in;
                end
            end
`ifdef ENEMY_PLOT_ERASE_EN
            StErase: begin
                if (w_last) begin
                    w_sel_cx = 4'd0;
                    w_sel_cy = 4'd0;
                end else begin
                    w_sel_ox     = w_prev_ox;
                    w_sel_oy     = w_prev_oy;
                    w_sel_colour = BG_COLOUR;
                end
            end
`endif
            StDraw: begin
                w_sel_colour = r_colour;
            end
            default: begin
                w_sel_colour = BG_COLOUR;
            end
        endcase
    end

    logic [8:0] w_px;
    logic [7:0] w_py;
    logic       w_on_screen;

    assign w_px        = {1'b0, w_sel_ox} + {5'b0, w_sel_cx};
    assign w_py        = {1'b0, w_sel_oy} + {4'b0, w_sel_cy};
    assign w_on_screen = (w_px < MaxX) && (w_py < MaxY);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_cx         <= 4'd0;
            r_cy         <= 4'd0;
            r_ox         <= 8'd0;
            r_oy         <= 7'd0;
            r_colour     <= 3'd0;
            r_vga_x      <= 8'd0;
            r_vga_y      <= 7'd0;
            r_vga_colour <= 3'd0;
            r_vga_plot   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef ENEMY_PLOT_ERASE_EN
            r_prev_ox    <= 8'd0;
            r_prev_oy    <= 7'd0;
            r_prev_valid <= 1'b0;
`endif
        end else begin
            r_vga_plot <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_ox         <= bus.x_in;
                        r_oy         <= bus.y_in;
                        r_colour     <= bus.colour_in;
                        r_cx         <= 4'd0;
                        r_cy         <= 4'd0;
                        r_busy       <= 1'b1;
                        r_vga_x      <= w_px[7:0];
                        r_vga_y      <= w_py[6:0];
                        r_vga_colour <= w_sel_colour;
                        r_vga_plot   <= w_on_screen;
`ifdef ENEMY_PLOT_ERASE_EN
                        r_state      <= w_prev_valid ? StErase : StDraw;
`else
                        r_state      <= StDraw;
`endif
                    end
                end
`ifdef ENEMY_PLOT_ERASE_EN
                StErase: begin
                    if (w_last) begin
                        r_state <= StDraw;
                    end
                    r_cx         <= w_sel_cx;
                    r_cy         <= w_sel_cy;
                    r_vga_x      <= w_px[7:0];
                    r_vga_y      <= w_py[6:0];
                    r_vga_colour <= w_sel_colour;
                    r_vga_plot   <= w_on_screen;
                end
`endif
                StDraw: begin
                    if (w_last) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
`ifdef ENEMY_PLOT_ERASE_EN
                        r_prev_ox    <= r_ox;
                        r_prev_oy    <= r_oy;
                        r_prev_valid <= 1'b1;
`endif
                    end else begin
                        r_cx         <= w_sel_cx;
                        r_cy         <= w_sel_cy;
                        r_vga_x      <= w_px[7:0];
                        r_vga_y      <= w_py[6:0];
                        r_vga_colour <= w_sel_colour;
                        r_vga_plot   <= w_on_screen;
                    end
                end
                StDone: begin
                    // Requests seen here are dropped; acceptance resumes in IDLE.
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_vga_y;
    assign bus.vga_colour = r_vga_colour;
    assign bus.vga_plot   = r_vga_plot;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
